// File: rtl/fp32_pkg.sv
// Shared constants and operand classification for the FP32 tap multiplier.
package fp32_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int BIAS     = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_cls_t;
endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of one float word: sign, exponent, 24-bit mantissa, class.
module fp32_classify
  import fp32_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] w,
  output logic                 sgn,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       mant,
  output fp_cls_t              cls
);
  always_comb begin
    sgn  = w[EXP_W+MAN_W];
    exp  = w[MAN_W +: EXP_W];
    mant = {1'b1, w[MAN_W-1:0]};
    // Denormals are flushed: exponent 0 is zero regardless of mantissa
    if (exp == '0)       cls = ZERO;
    else if (&exp)       cls = (w[MAN_W-1:0] == '0) ? INF : NAN;
    else                 cls = NORM;
  end
endmodule

// File: rtl/fp32_mul_pipe.sv
// 3-stage FP32 multiplier (truncate, FTZ) with a single global stall enable.
module fp32_mul_pipe
  import fp32_pkg::*;
#(
  parameter int EXP_W       = FP_EXP_W,
  parameter int MAN_W       = FP_MAN_W,
  parameter bit SIGNED_ZERO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] p,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;
  localparam int PW     = 2 * MW;
  localparam int EW     = EXP_W + 2;
  localparam int EBIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam int STAGES = 3;
  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             s, nan, inf, zero;
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
  } s1_t;

  typedef struct packed {
    logic                 s, nan, inf, zero;
    logic signed [EW-1:0] e;
    logic [PW-1:0]        m;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    p_d;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MW-1:0]    ma, mb;
  fp_cls_t          ca, cb;

  assign en          = ~vld_pipe[STAGES] | out_ready;
  assign in_ready    = en;
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  fp32_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.w(a), .sgn(sa), .exp(ea), .mant(ma), .cls(ca));
  fp32_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.w(b), .sgn(sb), .exp(eb), .mant(mb), .cls(cb));

  // S1: resolve the special-case flags up front so later stages only carry three bits
  always_comb begin
    s1_d      = '0;
    s1_d.s    = sa ^ sb;
    s1_d.nan  = (ca == NAN) || (cb == NAN) ||
                (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
    s1_d.inf  = (ca == INF) || (cb == INF);
    s1_d.zero = (ca == ZERO) || (cb == ZERO);
    s1_d.ea   = ea;
    s1_d.eb   = eb;
    s1_d.ma   = ma;
    s1_d.mb   = mb;
  end

  // S2: full-width product and unbiased-sum exponent with headroom for sign/overflow
  always_comb begin
    s2_d      = '0;
    s2_d.s    = s1_q.s;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.e    = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - EW'(EBIAS);
    s2_d.m    = PW'(s1_q.ma) * PW'(s1_q.mb);
  end

  // S3: normalise by at most one place, truncate, then apply result priority
  logic                 mtop;
  logic signed [EW-1:0] ne;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         zero_w;

  always_comb begin
    mtop   = s2_q.m[PW-1];
    ne     = s2_q.e + EW'(mtop);
    frac   = mtop ? s2_q.m[PW-2 -: MAN_W] : s2_q.m[PW-3 -: MAN_W];
    zero_w = {SIGNED_ZERO & s2_q.s, {(W-1){1'b0}}};
    if (s2_q.nan)                       p_d = QNAN_W;
    else if (s2_q.inf)                  p_d = {s2_q.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (s2_q.zero)                 p_d = zero_w;
    else if (ne >= $signed(EW'(EMAX)))  p_d = {s2_q.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ne <= 0)                   p_d = zero_w;
    else                                p_d = {s2_q.s, ne[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      s1_q               <= '0;
      s2_q               <= '0;
      p                  <= '0;
    end else if (en) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      s1_q               <= s1_d;
      s2_q               <= s2_d;
      p                  <= p_d;
    end
  end
endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed bench for fp32_mul_pipe: single vectors, stalled stream, mid-flight reset.
module tb_fp32_mul_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, p;
  logic        in_valid, in_ready, out_valid, out_ready;

  int total = 0;
  int bad   = 0;

  fp32_mul_pipe dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .p(p), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op into an idle pipe; out_valid must first appear in the 3rd cycle after accept
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ex);
    int n;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    chk({tag, "_lat"}, n, 32'd3);
    chk(tag, p, ex);
    @(posedge clk); #1;
    chk({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  logic [31:0] sa_v [6] = '{32'h3FC00000, 32'h3FC00000, 32'hBFC00000, 32'h40000000, 32'h3F800000, 32'h40400000};
  logic [31:0] sb_v [6] = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h40400000};
  logic [31:0] sp_v [6] = '{32'h40400000, 32'h40100000, 32'hC0400000, 32'h40800000, 32'h3F000000, 32'h41100000};

  initial begin
    int sent, recv, stale;
    logic acc, held_ok;
    logic [31:0] held_p;

    rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_p", p, 32'h0);
    chk("rst_rdy", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    run_one("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000);
    run_one("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000);
    run_one("mul_neg",     32'hBFC00000, 32'h40000000, 32'hC0400000);
    run_one("mul_negzero", 32'h3F800000, 32'h80000000, 32'h00000000);
    run_one("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000);
    run_one("inf_x_neg",   32'h7F800000, 32'hC0000000, 32'hFF800000);
    run_one("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run_one("ovf",         32'h7F000000, 32'h40000000, 32'h7F800000);
    run_one("unf",         32'h00800000, 32'h3F000000, 32'h00000000);

    // Stream of 6 with out_ready low for cycles 5..8
    sent = 0; recv = 0; held_ok = 1'b0; held_p = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      if (sent < 6) begin
        a = sa_v[sent]; b = sb_v[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid && !out_ready) begin
        chk("stall_rdy", {31'b0, in_ready}, 32'd0);
        if (held_ok) chk("stall_hold", p, held_p);
        held_p = p; held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (recv < 6) chk($sformatf("stream%0d", recv), p, sp_v[recv]);
        else chk("stream_dup", {31'b0, out_valid}, 32'd0);
        recv++;
      end
      if (acc) sent++;
    end
    chk("stream_cnt", recv, 32'd6);

    // Reset with two ops in flight
    @(negedge clk);
    out_ready = 1'b1; a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ov", {31'b0, out_valid}, 32'd0);
    chk("midrst_p", p, 32'h0);
    @(negedge clk); rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("midrst_stale", stale, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
